// File: rtl/snowball_port_arbiter.sv
// Three-port (T/D/I) arbiter in front of the cache/MMU, one transaction in flight.
// Define SNOWBALL_ARB_RR_EN to alternate D and I grants; T always wins.
module snowball_port_arbiter #(
    parameter logic [7:0] WD_LIMIT = 8'd200
) (
    input  logic        CPU_CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_fault,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_fault,
    input  logic        t_req,
    input  logic [31:0] t_addr,
    input  logic [31:0] t_wdata,
    output logic        t_ack,
    output logic [31:0] rdata,
    output logic [31:0] cache_precycle_addr,
    output logic [31:0] cache_datao,
    output logic        cache_precycle_we,
    output logic        cache_precycle_enable,
    output logic        WE_TLB,
    input  logic        cache_busy,
    input  logic [31:0] cache_datai,
    input  logic        MMU_FAULT,
    output logic        wd_err
);

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned WDW = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_LOOK  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PORT_I = 2'd0,
        PORT_D = 2'd1,
        PORT_T = 2'd2
    } port_t;

    state_t           r_state;
    port_t            r_port;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_we_lat;
    logic             r_pc_we;
    logic             r_pc_en;
    logic             r_we_tlb;
    logic [WDW-1:0]   r_wd;
`ifdef SNOWBALL_ARB_RR_EN
    logic             r_rr_d;
`endif

    logic             w_grant;
    port_t            w_win;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_wdata;
    logic             w_we;
    logic             w_mmu_fault;
    logic             w_chk_done;
    logic             w_wait_done;
    logic             w_wd_hit;
    logic             w_done;
    logic             w_fault;
    logic             w_rd_done;

    // Winner selection; only consumed while idle.
    always_comb begin
        w_grant = 1'b0;
        w_win   = PORT_D;
        if (t_req) begin
            w_grant = 1'b1;
            w_win   = PORT_T;
        end
`ifdef SNOWBALL_ARB_RR_EN
        else if (d_req && i_req) begin
            w_grant = 1'b1;
            w_win   = r_rr_d ? PORT_D : PORT_I;
        end
`endif
        else if (d_req) begin
            w_grant = 1'b1;
            w_win   = PORT_D;
        end else if (i_req) begin
            w_grant = 1'b1;
            w_win   = PORT_I;
        end
    end

    // Operand mux for the winner; fetches and TLB writes never write the cache.
    always_comb begin
        w_addr  = d_addr;
        w_wdata = d_wdata;
        w_we    = 1'b0;
        case (w_win)
            PORT_T: begin
                w_addr  = t_addr;
                w_wdata = t_wdata;
            end
            PORT_D: begin
                w_addr  = d_addr;
                w_wdata = d_wdata;
                w_we    = d_we;
            end
            default: begin
                w_addr  = i_addr;
                w_wdata = d_wdata;
            end
        endcase
    end

    // Completion decode from registered state plus live cache status.
    assign w_mmu_fault = MMU_FAULT && (r_port != PORT_T);
    assign w_chk_done  = (r_state == ST_CHECK) && (w_mmu_fault || !cache_busy);
    assign w_wait_done = (r_state == ST_WAIT) && !cache_busy;
    assign w_wd_hit    = (r_state == ST_WAIT) && cache_busy && (r_wd == WD_LIMIT);
    assign w_done      = w_chk_done || w_wait_done || w_wd_hit;
    assign w_fault     = ((r_state == ST_CHECK) && w_mmu_fault) || w_wd_hit;
    assign w_rd_done   = w_done && !w_fault && (r_port != PORT_T) && !r_we_lat;

    assign i_ack   = w_done && (r_port == PORT_I);
    assign d_ack   = w_done && (r_port == PORT_D);
    assign t_ack   = w_done && (r_port == PORT_T);
    assign i_fault = i_ack && w_fault;
    assign d_fault = d_ack && w_fault;
    assign wd_err  = w_wd_hit;
    assign rdata   = w_rd_done ? cache_datai : '0;

    assign cache_precycle_addr   = r_addr;
    assign cache_datao           = r_wdata;
    assign cache_precycle_we     = r_pc_we;
    assign cache_precycle_enable = r_pc_en;
    assign WE_TLB                = r_we_tlb;

    // Transaction FSM; strobes are set on grant so they are high only in ISSUE.
    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_port   <= PORT_I;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we_lat <= 1'b0;
            r_pc_we  <= 1'b0;
            r_pc_en  <= 1'b0;
            r_we_tlb <= 1'b0;
            r_wd     <= '0;
`ifdef SNOWBALL_ARB_RR_EN
            r_rr_d   <= 1'b1;
`endif
        end else begin
            r_pc_we  <= 1'b0;
            r_pc_en  <= 1'b0;
            r_we_tlb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_port   <= w_win;
                        r_addr   <= w_addr;
                        r_wdata  <= w_wdata;
                        r_we_lat <= w_we;
                        r_pc_we  <= w_we;
                        r_pc_en  <= (w_win != PORT_T);
                        r_we_tlb <= (w_win == PORT_T);
                        r_state  <= ST_ISSUE;
`ifdef SNOWBALL_ARB_RR_EN
                        if (w_win != PORT_T) begin
                            r_rr_d <= (w_win == PORT_I);
                        end
`endif
                    end
                end
                ST_ISSUE: r_state <= ST_LOOK;
                ST_LOOK:  r_state <= ST_CHECK;
                ST_CHECK: begin
                    if (w_chk_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                        r_wd    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_wait_done || w_wd_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snowball_port_arbiter.sv
// Directed bench for snowball_port_arbiter with an ack scoreboard.
// Expected grant order follows SNOWBALL_ARB_RR_EN when defined.
module tb_snowball_port_arbiter;

    logic        CPU_CLK = 1'b0;
    logic        RST = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, t_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, t_addr = '0, t_wdata = '0;
    logic        cache_busy = 1'b0, MMU_FAULT = 1'b0;
    logic [31:0] cache_datai = '0;
    logic        i_ack, i_fault, d_ack, d_fault, t_ack;
    logic        cache_precycle_we, cache_precycle_enable, WE_TLB, wd_err;
    logic [31:0] rdata, cache_precycle_addr, cache_datao;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic        fault;
        logic        wd;
        logic        chk_rdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    snowball_port_arbiter #(.WD_LIMIT(8'd200)) dut (
        .CPU_CLK(CPU_CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_fault(i_fault),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_fault(d_fault),
        .t_req(t_req), .t_addr(t_addr), .t_wdata(t_wdata), .t_ack(t_ack),
        .rdata(rdata),
        .cache_precycle_addr(cache_precycle_addr), .cache_datao(cache_datao),
        .cache_precycle_we(cache_precycle_we), .cache_precycle_enable(cache_precycle_enable),
        .WE_TLB(WE_TLB), .cache_busy(cache_busy), .cache_datai(cache_datai),
        .MMU_FAULT(MMU_FAULT), .wd_err(wd_err)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input logic fault, input logic wd,
                        input logic chk, input logic [31:0] rd);
        exp_t e;
        e.port = port; e.fault = fault; e.wd = wd; e.chk_rdata = chk; e.rdata = rd;
        sb.push_back(e);
    endtask

    // Start of a new cycle: inputs are driven here.
    task automatic next_cycle();
        @(posedge CPU_CLK);
        #1;
    endtask

    // Middle of the current cycle: outputs are sampled here.
    task automatic at_mid();
        @(negedge CPU_CLK);
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        at_mid();
        while (!(i_ack === 1'b1 || d_ack === 1'b1 || t_ack === 1'b1) && n < budget) begin
            next_cycle();
            n++;
            at_mid();
        end
        check1("ack_seen", i_ack | d_ack | t_ack, 1'b1);
    endtask

    task automatic check_quiet(input string tag);
        check32({tag, "_ctl"}, {27'd0, cache_precycle_enable, WE_TLB, cache_precycle_we,
                wd_err, i_ack | d_ack | t_ack}, 32'd0);
        check32({tag, "_addr"}, cache_precycle_addr, 32'd0);
        check32({tag, "_datao"}, cache_datao, 32'd0);
        check32({tag, "_rdata"}, rdata, 32'd0);
    endtask

    // Scoreboard: every ack pops the oldest expectation.
    always @(negedge CPU_CLK) begin
        if (i_ack === 1'b1 || d_ack === 1'b1 || t_ack === 1'b1) begin
            exp_t e;
            int   p;
            check32("ack_onehot", 32'(i_ack) + 32'(d_ack) + 32'(t_ack), 32'd1);
            p = i_ack ? 0 : (d_ack ? 1 : 2);
            if (sb.size() == 0) begin
                check32("unexpected_ack", {29'd0, t_ack, d_ack, i_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check32("ack_port", 32'(p), 32'(e.port));
                if (p == 0) check1("i_fault", i_fault, e.fault);
                else if (p == 1) check1("d_fault", d_fault, e.fault);
                else check32("t_nofault", {30'd0, i_fault, d_fault}, 32'd0);
                check1("wd_err", wd_err, e.wd);
                if (e.chk_rdata) check32("rdata", rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int dn;
        int in_n;
        logic d_drop;
        logic i_drop;

        // Reset state
        repeat (3) next_cycle();
        RST = 1'b1;
        at_mid();
        check_quiet("reset");

        // D read hit
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; cache_datai = 32'hDEADBEEF;
        push(1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        at_mid();
        check1("hit_c1_en", cache_precycle_enable, 1'b0);
        next_cycle(); at_mid();
        check1("hit_c2_en", cache_precycle_enable, 1'b1);
        check32("hit_c2_addr", cache_precycle_addr, 32'h0000_0040);
        check1("hit_c2_we", cache_precycle_we, 1'b0);
        next_cycle(); at_mid();
        check1("hit_c3_en", cache_precycle_enable, 1'b0);
        check1("hit_c3_ack", d_ack, 1'b0);
        next_cycle(); at_mid();
        check1("hit_c4_ack", d_ack, 1'b1);
        check32("hit_c4_addr_hold", cache_precycle_addr, 32'h0000_0040);
        next_cycle();
        d_req = 1'b0;

        // D write, busy for 10 cycles from CHECK
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h5A5A_0001;
        push(1, 1'b0, 1'b0, 1'b0, 32'd0);
        next_cycle(); at_mid();
        check1("wr_c2_en", cache_precycle_enable, 1'b1);
        check1("wr_c2_we", cache_precycle_we, 1'b1);
        check32("wr_c2_datao", cache_datao, 32'h5A5A_0001);
        next_cycle(); at_mid();
        check1("wr_c3_we", cache_precycle_we, 1'b0);
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            cache_busy = 1'b1;
            at_mid();
            check1("wr_busy_noack", d_ack, 1'b0);
        end
        next_cycle();
        cache_busy = 1'b0;
        at_mid();
        check1("wr_ack", d_ack, 1'b1);
        check1("wr_fault", d_fault, 1'b0);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;

        // I fetch with MMU fault in CHECK, busy high so WAIT would stall
        i_req = 1'b1; i_addr = 32'h0000_1000;
        push(0, 1'b1, 1'b0, 1'b0, 32'd0);
        next_cycle(); at_mid();
        check1("if_c2_we", cache_precycle_we, 1'b0);
        next_cycle();
        next_cycle();
        MMU_FAULT = 1'b1; cache_busy = 1'b1;
        at_mid();
        check1("if_c4_ack", i_ack, 1'b1);
        check1("if_c4_fault", i_fault, 1'b1);
        next_cycle();
        MMU_FAULT = 1'b0; cache_busy = 1'b0; i_req = 1'b0;
        at_mid();
        check1("if_c5_noack", i_ack, 1'b0);

        // Reset, then I and D contend for three grants each
        next_cycle();
        RST = 1'b0;
        next_cycle();
        RST = 1'b1;
        at_mid();
        check_quiet("reset2");
`ifdef SNOWBALL_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            push(1, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001);
            push(0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001);
        end
`else
        for (int k = 0; k < 3; k++) push(1, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001);
        for (int k = 0; k < 3; k++) push(0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001);
`endif
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        cache_datai = 32'hC0DE_0001;
        dn = 0; in_n = 0; d_drop = 1'b0; i_drop = 1'b0;
        for (int k = 0; k < 60 && !(dn == 3 && in_n == 3); k++) begin
            at_mid();
            if (d_ack === 1'b1) begin dn++; if (dn == 3) d_drop = 1'b1; end
            if (i_ack === 1'b1) begin in_n++; if (in_n == 3) i_drop = 1'b1; end
            next_cycle();
            if (d_drop) d_req = 1'b0;
            if (i_drop) i_req = 1'b0;
        end
        check32("b2b_d_count", 32'(dn), 32'd3);
        check32("b2b_i_count", 32'(in_n), 32'd3);

        // Watchdog: busy stuck after CHECK
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        push(1, 1'b1, 1'b1, 1'b0, 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        cache_busy = 1'b1;
        at_mid();
        check1("wd_check_noack", d_ack, 1'b0);
        next_cycle();
        wait_ack(300, n);
        check32("wd_latency", 32'(n), 32'd200);
        check1("wd_err_pulse", wd_err, 1'b1);
        check1("wd_d_fault", d_fault, 1'b1);
        next_cycle();
        cache_busy = 1'b0; d_addr = 32'h0000_0204; cache_datai = 32'h1234_5678;
        push(1, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        at_mid();
        check1("wd_next_err", wd_err, 1'b0);
        check1("wd_next_en", cache_precycle_enable, 1'b0);
        next_cycle(); at_mid();
        check1("wd_regrant_en", cache_precycle_enable, 1'b1);
        check32("wd_regrant_addr", cache_precycle_addr, 32'h0000_0204);
        next_cycle();
        d_req = 1'b0;
        wait_ack(10, n);
        check32("dropped_req_latency", 32'(n), 32'd1);

        // T beats D; reset during the following D WAIT
        next_cycle();
        t_req = 1'b1; t_addr = 32'h0000_0300; t_wdata = 32'hABCD_1234;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h0BAD_F00D;
        push(2, 1'b0, 1'b0, 1'b0, 32'd0);
        next_cycle(); at_mid();
        check1("t_c2_wetlb", WE_TLB, 1'b1);
        check1("t_c2_en", cache_precycle_enable, 1'b0);
        check1("t_c2_we", cache_precycle_we, 1'b0);
        check32("t_c2_addr", cache_precycle_addr, 32'h0000_0300);
        check32("t_c2_datao", cache_datao, 32'hABCD_1234);
        next_cycle(); at_mid();
        check1("t_c3_wetlb", WE_TLB, 1'b0);
        next_cycle(); at_mid();
        check1("t_c4_ack", t_ack, 1'b1);
        next_cycle();
        t_req = 1'b0;
        next_cycle(); at_mid();
        check1("t_then_d_en", cache_precycle_enable, 1'b1);
        check32("t_then_d_addr", cache_precycle_addr, 32'h0000_0400);
        next_cycle();
        next_cycle();
        cache_busy = 1'b1;
        next_cycle();
        next_cycle();
        RST = 1'b0; d_req = 1'b0;
        next_cycle();
        RST = 1'b1; cache_busy = 1'b0;
        at_mid();
        check_quiet("midreset");
        for (int k = 0; k < 5; k++) begin
            next_cycle(); at_mid();
            check1("midreset_noack", d_ack, 1'b0);
        end

        check32("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snowball_port_arbiter.md
SNOWBALL_PORT_ARBITER -- requirements
Module: snowball_port_arbiter

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 8'd200, WAIT-state watchdog limit in CPU_CLK cycles.
REQ-002 SHALL have ports: CPU_CLK  in  1  clock, all logic on rising edge; RST  in  1  synchronous active-low reset.
REQ-003 SHALL have I-port: i_req in 1 fetch request level; i_addr in 32 fetch address; i_ack out 1 one-cycle completion pulse; i_fault out 1 valid with i_ack.
REQ-004 SHALL have D-port: d_req in 1; d_we in 1 write when 1; d_addr in 32; d_wdata in 32; d_ack out 1; d_fault out 1.
REQ-005 SHALL have T-port: t_req in 1 TLB-write request; t_addr in 32; t_wdata in 32 {tag[31:16],mmu[15:0]}; t_ack out 1.
REQ-006 SHALL share rdata out 32, valid with i_ack or d_ack (read).
REQ-007 SHALL have cache side: cache_precycle_addr out 32; cache_datao out 32; cache_precycle_we out 1; cache_precycle_enable out 1; WE_TLB out 1; cache_busy in 1; cache_datai in 32; MMU_FAULT in 1.
REQ-008 SHALL have wd_err out 1, one-cycle pulse on watchdog expiry.

Function
REQ-009 SHALL run FSM IDLE, ISSUE, LOOK, CHECK, WAIT; one outstanding transaction only.
REQ-010 IDLE: if any req, SHALL latch winner, its address, data and we into registers, then go to ISSUE next cycle.
REQ-011 Priority SHALL be T > D > I, evaluated only in IDLE.
REQ-012 ISSUE: SHALL drive cache_precycle_enable=1 (D/I) or WE_TLB=1 (T) for exactly one cycle, with registered addr/datao/we; I-port forces we=0; T-port forces cache_precycle_we=0.
REQ-013 Outside ISSUE, enable, WE_TLB and we SHALL be 0; addr/datao hold last value.
REQ-014 LOOK: SHALL wait one cycle unconditionally, then go to CHECK.
REQ-015 CHECK: if MMU_FAULT=1 (D/I), SHALL pulse winner ack with fault=1 this cycle and go to IDLE; rdata undefined.
REQ-016 CHECK: else if cache_busy=0, SHALL pulse ack with fault=0, rdata=cache_datai, go to IDLE.
REQ-017 CHECK: else SHALL go to WAIT, clearing a watchdog counter.
REQ-018 WAIT: SHALL pulse ack with rdata=cache_datai in the first cycle cache_busy is sampled 0, then go to IDLE.
REQ-019 WAIT: counter SHALL increment per cycle; on reaching WD_LIMIT SHALL pulse ack, fault=1 (T: ack only) and wd_err=1, and go to IDLE.
REQ-020 Hit latency SHALL be 4 cycles from req sampled in IDLE to ack (IDLE, ISSUE, LOOK, CHECK); next grant possible the cycle after ack.
REQ-021 Requesters SHALL hold req and operands stable until ack; arbiter SHALL sample them only in IDLE; req dropped after latch still completes with ack.
REQ-022 At most one ack SHALL be high per cycle; acks, faults and wd_err SHALL be combinational from registered state and cache inputs sampled in CHECK/WAIT.
REQ-023 If cache_busy=1 in IDLE, arbiter SHALL still issue; the cache queues internally.

Reset
REQ-024 RST=0 at a clock edge SHALL force IDLE, all registered outputs 0, latched addr/data 0, watchdog 0, RR pointer to D.
REQ-025 Reset mid-transaction SHALL drop it with no ack; requesters reissue.

Configuration
REQ-026 Macro SNOWBALL_ARB_RR_EN: defined, I and D SHALL alternate when both pending and T idle (pointer flips on each I/D grant); undefined, fixed T > D > I.
REQ-027 T-port SHALL keep top priority in both builds.

Verification
REQ-028 D read, hit (cache_busy stays 0, cache_datai=32'hDEADBEEF) -> enable pulse in cycle 2, d_ack and rdata=32'hDEADBEEF in cycle 4.
REQ-029 D write to 32'h0000_0100, cache_busy high 10 cycles from CHECK -> d_ack in first cycle busy=0, d_fault=0.
REQ-030 i_req and d_req together, 3 back-to-back each -> without macro D,D,D,I,I,I; with SNOWBALL_ARB_RR_EN D,I,D,I,D,I.
REQ-031 I fetch with MMU_FAULT=1 in CHECK -> i_ack and i_fault=1 in cycle 4, no WAIT.
REQ-032 cache_busy stuck 1, WD_LIMIT=8'd200 -> ack, fault=1 and wd_err=1 exactly 200 cycles after WAIT entry, FSM in IDLE next cycle.
REQ-033 t_req with d_req, RST low during WAIT -> T granted first (WE_TLB pulse); after reset no ack, all outputs 0, IDLE.
